// File: rtl/register_file.sv
// 32 x 32 integer register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, same-cycle write-to-read bypass.
module register_file #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              en,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic [DATA_W-1:0] rda,
   output logic [DATA_W-1:0] rdb
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              write_fire;

   // A write to x0 is dropped here so neither storage nor bypass ever sees it.
   assign write_fire = en && reg_write && (rd != '0);

   // NOTE: the storage array is reset on purpose -- registers must read 0 after
   // reset, so every entry needs the async clear, unlike a RAM macro.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            // NOTE: non-blocking for all sequential state, so every flop
            // samples pre-edge values regardless of process ordering.
            regs[i] <= '0;
         end
      end else if (write_fire) begin
         regs[rd] <= write_data;
      end
   end

   // Reads: reset forces 0, then x0, then the bypass, then storage.
   always_comb begin
      // NOTE: defaults first so every path assigns the outputs -- no latches.
      rda = '0;
      rdb = '0;
      if (nRst) begin
         if (rs1 != '0) begin
            rda = (write_fire && (rd == rs1)) ? write_data : regs[rs1];
         end
         if (rs2 != '0) begin
            rdb = (write_fire && (rd == rs2)) ? write_data : regs[rs2];
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases with literal
// expectations plus randomized traffic compared against an array model.
module tb_register_file;

   localparam int NUM_REGS = 32;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;

   logic              clk = 1'b0;
   logic              nRst;
   logic              en;
   logic              reg_write;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] write_data;
   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic [DATA_W-1:0] rda;
   logic [DATA_W-1:0] rdb;

   int total = 0;
   int bad   = 0;
   bit auto_check = 1'b0;

   logic [DATA_W-1:0] model [NUM_REGS];

   register_file #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .nRst(nRst), .en(en), .reg_write(reg_write), .rd(rd),
      .write_data(write_data), .rs1(rs1), .rs2(rs2), .rda(rda), .rdb(rdb)
   );

   always #5 clk = ~clk;

   // Architectural model: the register array as the ISA sees it.
   always @(negedge nRst) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
   end

   always @(posedge clk) begin
      if (nRst === 1'b1 && en && reg_write && rd != 0) model[rd] = write_data;
   end

   function automatic logic [DATA_W-1:0] expect_read(input logic [ADDR_W-1:0] idx);
      if (nRst !== 1'b1) return '0;
      if (idx == 0) return '0;
      if (en && reg_write && rd == idx) return write_data;
      return model[idx];
   endfunction

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (auto_check) begin
         check("model_rda", rda, expect_read(rs1));
         check("model_rdb", rdb, expect_read(rs2));
      end
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] val);
      en = 1'b1; reg_write = 1'b1; rd = idx; write_data = val;
      step();
      reg_write = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      nRst = 1'b0; en = 1'b1; reg_write = 1'b0; rd = '0; write_data = '0;
      rs1 = '0; rs2 = '0;
      repeat (2) step();
      nRst = 1'b1;
      step();

      // Reset state
      rs1 = 5'd7; rs2 = 5'd31; #1;
      check("reset_rda", rda, 32'h0);
      check("reset_rdb", rdb, 32'h0);

      // Async reset clears without a clock edge
      write_reg(5'd5, 32'hDEADBEEF);
      rs1 = 5'd5; #1;
      check("x5_written", rda, 32'hDEADBEEF);
      nRst = 1'b0; #1;
      check("async_reset_rda", rda, 32'h0);
      nRst = 1'b1; #1;
      check("after_reset_x5", rda, 32'h0);
      step();

      // Reset asserted across a write edge loses the write
      en = 1'b1; reg_write = 1'b1; rd = 5'd6; write_data = 32'h12345678; rs1 = 5'd6;
      nRst = 1'b0;
      step();
      nRst = 1'b1; reg_write = 1'b0; #1;
      check("reset_mid_write", rda, 32'h0);
      step();

      // Basic write/read
      write_reg(5'd1, 32'd10);
      write_reg(5'd2, 32'd5);
      rs1 = 5'd1; rs2 = 5'd2; #1;
      check("basic_rda", rda, 32'd10);
      check("basic_rdb", rdb, 32'd5);
      check("basic_sum", rda + rdb, 32'd15);

      // x0 protection, same cycle and next
      en = 1'b1; reg_write = 1'b1; rd = 5'd0; write_data = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0; #1;
      check("x0_same_cycle", rda, 32'h0);
      check("x0_same_cycle_b", rdb, 32'h0);
      step();
      reg_write = 1'b0; #1;
      check("x0_next_cycle", rda, 32'h0);

      // Bypass on both ports
      write_reg(5'd3, 32'd7);
      en = 1'b1; reg_write = 1'b1; rd = 5'd3; write_data = 32'hFFFFFFF6; rs1 = 5'd3; rs2 = 5'd3; #1;
      check("bypass_rda", rda, 32'hFFFFFFF6);
      check("bypass_rdb", rdb, 32'hFFFFFFF6);
      step();
      reg_write = 1'b0; #1;
      check("bypass_stored_rda", rda, 32'hFFFFFFF6);
      check("bypass_stored_rdb", rdb, 32'hFFFFFFF6);

      // Stall suppresses write and bypass
      write_reg(5'd4, 32'd1);
      en = 1'b0; reg_write = 1'b1; rd = 5'd4; write_data = 32'd2147483647; rs1 = 5'd4; #1;
      check("stall_before_edge", rda, 32'd1);
      step();
      check("stall_after_edge", rda, 32'd1);
      en = 1'b1; #1;
      check("unstall_bypass", rda, 32'd2147483647);
      step();
      reg_write = 1'b0; #1;
      check("unstall_stored", rda, 32'd2147483647);

      // Back-to-back writes to one register: last wins
      write_reg(5'd9, 32'hA5A5A5A5);
      write_reg(5'd9, 32'h5A5A5A5A);
      rs1 = 5'd9; #1;
      check("last_write_wins", rda, 32'h5A5A5A5A);

      // Sweep every register
      for (int i = 1; i < NUM_REGS; i++) write_reg(ADDR_W'(i), DATA_W'(i * 4 + 1));
      for (int i = 0; i < NUM_REGS; i++) begin
         rs1 = ADDR_W'(i); rs2 = ADDR_W'(31 - i); #1;
         check("sweep_rda", rda, (i == 0) ? 32'h0 : DATA_W'(i * 4 + 1));
         check("sweep_rdb", rdb, (i == 31) ? 32'h0 : DATA_W'((31 - i) * 4 + 1));
      end
      step();

      // Randomized traffic against the model
      auto_check = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         en         = ($urandom_range(0, 7) != 0);
         reg_write  = ($urandom_range(0, 3) != 0);
         rd         = ADDR_W'($urandom_range(0, NUM_REGS - 1));
         write_data = $urandom();
         rs1        = ($urandom_range(0, 3) == 0) ? rd : ADDR_W'($urandom_range(0, NUM_REGS - 1));
         rs2        = ($urandom_range(0, 3) == 0) ? rd : ADDR_W'($urandom_range(0, NUM_REGS - 1));
         if ($urandom_range(0, 199) == 0) begin
            #1 nRst = 1'b0;
            #1 nRst = 1'b1;
         end
         step();
      end
      auto_check = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
